score_display_scan: RTL and testbench

Time-multiplexed driver for the 4-digit seven-segment score display of the snake game. Latches an 8-bit binary score, converts it to BCD with a sequential shift-add-3 engine, and scans the 4 digit positions. Each scan slot emits one 8-bit digit code, which feeds the combinational segment encoder, plus an active-low anode pattern. A level `game_over` input overrides the score with the text "LOSE".

---
 rtl/seg_codes_pkg.sv | 40 ++++
 rtl/bin2bcd_seq.sv | 82 ++++++++
 rtl/score_display_scan.sv | 124 ++++++++++++
 tb/tb_score_display_scan.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_codes_pkg.sv
// Digit codes for the score display segment encoder and the BCD conversion state type.
package seg_codes_pkg;

    typedef enum logic [7:0] {
        DIG_0    = 8'h00,
        DIG_1    = 8'h01,
        DIG_2    = 8'h02,
        DIG_3    = 8'h03,
        DIG_4    = 8'h04,
        DIG_5    = 8'h05,
        DIG_6    = 8'h06,
        DIG_7    = 8'h07,
        DIG_8    = 8'h08,
        DIG_9    = 8'h09,
        CH_S     = 8'h0A,
        CH_R     = 8'h0B,
        CH_C     = 8'h0C,
        CH_E     = 8'h0E,
        CH_L     = 8'h11,
        CH_MINUS = 8'hFE,
        CH_BLANK = 8'hFF
    } seg_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADJ,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // A nibble above 9 cannot come out of the converter; show minus rather than garbage.
    function automatic logic [7:0] numeral_code(input logic [3:0] n);
        return (n <= 4'd9) ? {4'h0, n} : CH_MINUS;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one ADJ and one SHIFT cycle per input bit.
// done is high during the COMMIT cycle; start in that cycle chains straight into a new conversion.
module bin2bcd_seq
    import seg_codes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  din,
    output logic        busy,
    output logic        done,
    output logic [11:0] result
);

    conv_state_t r_state;
    conv_state_t w_state_nxt;
    logic [7:0]  r_bin;
    logic [7:0]  w_bin_nxt;
    logic [11:0] r_bcd;
    logic [11:0] w_bcd_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bin   <= 8'h00;
            r_bcd   <= 12'h000;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
            r_bcd   <= w_bcd_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_bcd_nxt   = r_bcd;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_bin_nxt   = din;
                    w_bcd_nxt   = 12'h000;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = ST_ADJ;
                end
            end
            ST_ADJ: begin
                w_bcd_nxt   = {add3_if_ge5(r_bcd[11:8]),
                               add3_if_ge5(r_bcd[7:4]),
                               add3_if_ge5(r_bcd[3:0])};
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_bcd_nxt   = {r_bcd[10:0], r_bin[7]};
                w_bin_nxt   = {r_bin[6:0], 1'b0};
                w_cnt_nxt   = r_cnt + 3'd1;
                w_state_nxt = (r_cnt == 3'd7) ? ST_COMMIT : ST_ADJ;
            end
            ST_COMMIT: begin
                if (start) begin
                    w_bin_nxt   = din;
                    w_bcd_nxt   = 12'h000;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = ST_ADJ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_COMMIT);
    assign result = r_bcd;

endmodule

// File: rtl/score_display_scan.sv
// 4-digit multiplexed score display: latches scores through a one-deep pending buffer,
// converts them to BCD and scans "S hhh tt o" (or "LOSE") across the digits.
module score_display_scan
    import seg_codes_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score,
    input  logic       score_valid,
    input  logic       game_over,
    output logic       busy,
    output logic [7:0] digit_code,
    output logic [3:0] anode
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic        w_eng_busy;
    logic        w_eng_done;
    logic        w_eng_start;
    logic [7:0]  w_eng_din;
    logic [11:0] w_eng_result;

    logic        r_pend_flag;
    logic [7:0]  r_pend_val;

    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;

    logic [CNT_W-1:0] r_refresh;
    logic             w_wrap;
    logic [1:0]       r_digit_sel;

    logic [3:0][7:0] w_content;
    logic [7:0]      r_digit_code;
    logic [3:0]      r_anode;

    // A strobe in the COMMIT cycle is newer than anything pending, so it is taken directly.
    assign w_eng_start = (score_valid && !w_eng_busy) ||
                         (w_eng_done && (r_pend_flag || score_valid));
    assign w_eng_din   = score_valid ? score : r_pend_val;

    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (w_eng_start),
        .din    (w_eng_din),
        .busy   (w_eng_busy),
        .done   (w_eng_done),
        .result (w_eng_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_flag <= 1'b0;
            r_pend_val  <= 8'h00;
        end else if (w_eng_done) begin
            r_pend_flag <= 1'b0;
        end else if (score_valid && w_eng_busy) begin
            r_pend_flag <= 1'b1;
            r_pend_val  <= score;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hund <= 4'd0;
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (w_eng_done) begin
            r_hund <= w_eng_result[11:8];
            r_tens <= w_eng_result[7:4];
            r_ones <= w_eng_result[3:0];
        end
    end

    assign busy   = w_eng_busy || r_pend_flag;
    assign w_wrap = (r_refresh == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh   <= '0;
            r_digit_sel <= 2'd0;
        end else if (w_wrap) begin
            r_refresh   <= '0;
            r_digit_sel <= r_digit_sel + 2'd1;
        end else begin
            r_refresh   <= r_refresh + CNT_W'(1);
        end
    end

    always_comb begin
        w_content = {4{8'(CH_BLANK)}};
        if (game_over) begin
            w_content[3] = CH_L;
            w_content[2] = DIG_0;
            w_content[1] = CH_S;
            w_content[0] = CH_E;
        end else begin
            w_content[3] = CH_S;
            w_content[2] = (r_hund == 4'd0) ? 8'(CH_BLANK) : numeral_code(r_hund);
            w_content[1] = (r_hund == 4'd0 && r_tens == 4'd0) ? 8'(CH_BLANK)
                                                              : numeral_code(r_tens);
            w_content[0] = numeral_code(r_ones);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_anode      <= 4'b1111;
            r_digit_code <= CH_BLANK;
        end else begin
            r_anode      <= ~(4'b0001 << r_digit_sel);
            r_digit_code <= w_content[r_digit_sel];
        end
    end

    assign anode      = r_anode;
    assign digit_code = r_digit_code;

endmodule

// File: tb/tb_score_display_scan.sv
// Self-checking bench for score_display_scan with a short refresh period.
module tb_score_display_scan;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] score = 8'h00;
    logic       score_valid = 1'b0;
    logic       game_over = 1'b0;
    logic       busy;
    logic [7:0] digit_code;
    logic [3:0] anode;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] cap [4];

    typedef struct {
        logic [7:0]  s;
        bit          go;
        logic [31:0] exp;   // {digit3, digit2, digit1, digit0}
    } vec_t;
    vec_t vecs [6];

    score_display_scan #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .score       (score),
        .score_valid (score_valid),
        .game_over   (game_over),
        .busy        (busy),
        .digit_code  (digit_code),
        .anode       (anode)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference content from decimal arithmetic on the score.
    function automatic logic [31:0] model_disp(input int s, input bit go);
        int h, t, o;
        logic [7:0] d3, d2, d1, d0;
        if (go) return 32'h11000A0E;
        h  = s / 100;
        t  = (s / 10) % 10;
        o  = s % 10;
        d3 = 8'h0A;
        d2 = (h == 0) ? 8'hFF : 8'(h);
        d1 = (h == 0 && t == 0) ? 8'hFF : 8'(t);
        d0 = 8'(o);
        return {d3, d2, d1, d0};
    endfunction

    function automatic int anode_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] s);
        score       = s;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        chk({name, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_digits(input string name, input logic [31:0] exp);
        bit [3:0] seen = 4'h0;
        int i;
        for (int c = 0; c < 4 * DIV + 4 && seen != 4'hF; c++) begin
            tick();
            i = anode_idx(anode);
            if (i >= 0) begin
                cap[i]  = digit_code;
                seen[i] = 1'b1;
            end
        end
        chk({name, " scan"}, 32'(seen), 32'hF);
        for (int d = 0; d < 4; d++)
            if (seen[d])
                chk($sformatf("%s d%0d", name, d), 32'(cap[d]), 32'(exp[8*d +: 8]));
    endtask

    initial begin
        logic [3:0]  exp_an [4];
        logic [7:0]  exp_cd [4];
        logic [31:0] m;
        bit          all_high;
        int          idx, cnt, s, d;
        bit          go;

        vecs[0] = '{s: 8'd7,   go: 1'b0, exp: 32'h0AFFFF07};
        vecs[1] = '{s: 8'd100, go: 1'b0, exp: 32'h0A010000};
        vecs[2] = '{s: 8'd10,  go: 1'b0, exp: 32'h0AFF0100};
        vecs[3] = '{s: 8'd0,   go: 1'b0, exp: 32'h0AFFFF00};
        vecs[4] = '{s: 8'd99,  go: 1'b0, exp: 32'h0AFF0909};
        vecs[5] = '{s: 8'd59,  go: 1'b1, exp: 32'h11000A0E};

        // Reset values and first scan pass
        repeat (3) tick();
        chk("rst anode", 32'(anode), 32'hF);
        chk("rst code", 32'(digit_code), 32'hFF);
        chk("rst busy", 32'(busy), 32'd0);
        exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_cd = '{8'h00, 8'hFF, 8'hFF, 8'h0A};
        rst = 1'b0;
        for (int slot = 0; slot < 4; slot++)
            for (int c = 0; c < DIV; c++) begin
                tick();
                chk($sformatf("scan anode s%0d c%0d", slot, c), 32'(anode), 32'(exp_an[slot]));
                chk($sformatf("scan code s%0d c%0d", slot, c), 32'(digit_code), 32'(exp_cd[slot]));
            end

        // 255: busy window and display-update latency
        strobe(8'd255);
        chk("255 busy e0", 32'(busy), 32'd1);
        all_high = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (!busy) all_high = 1'b0;
        end
        chk("255 busy e1-16", 32'(all_high), 32'd1);
        tick();
        chk("255 busy e17", 32'(busy), 32'd0);
        idx = anode_idx(anode);
        m   = model_disp(0, 1'b0);
        chk("255 old code e17", 32'(digit_code), 32'(m[8*idx +: 8]));
        tick();
        idx = anode_idx(anode);
        m   = model_disp(255, 1'b0);
        chk("255 new code e18", 32'(digit_code), 32'(m[8*idx +: 8]));
        check_digits("255", 32'h0A020505);

        // Table-driven vectors
        foreach (vecs[v]) begin
            game_over = vecs[v].go;
            strobe(vecs[v].s);
            wait_idle($sformatf("vec%0d", v), 40);
            check_digits($sformatf("vec%0d", v), vecs[v].exp);
        end
        game_over = 1'b0;

        // game_over takes and releases control on the next output update
        tick();
        game_over = 1'b1;
        tick();
        idx = anode_idx(anode);
        m   = model_disp(0, 1'b1);
        chk("go on next cycle", 32'(digit_code), 32'(m[8*idx +: 8]));
        check_digits("go", 32'h11000A0E);
        game_over = 1'b0;
        tick();
        idx = anode_idx(anode);
        m   = model_disp(59, 1'b0);
        chk("go off next cycle", 32'(digit_code), 32'(m[8*idx +: 8]));

        // Overrun: 42, then 200 and 13 back to back; 200 is dropped
        strobe(8'd42);
        all_high = 1'b1;
        score = 8'd200; score_valid = 1'b1; tick();
        score = 8'd13;  tick();
        score_valid = 1'b0;
        for (int k = 3; k <= 18; k++) begin
            tick();
            if (!busy) all_high = 1'b0;
        end
        idx = anode_idx(anode);
        m   = model_disp(42, 1'b0);
        chk("ovr 42 first", 32'(digit_code), 32'(m[8*idx +: 8]));
        cnt = 18;
        while (busy && cnt < 60) begin
            tick();
            cnt++;
        end
        chk("ovr busy held", 32'(all_high), 32'd1);
        chk("ovr busy falls e34", 32'(cnt), 32'd34);
        check_digits("ovr", 32'h0AFF0103);

        // Randomised scores, optional second strobe, random game_over
        for (int it = 0; it < 16; it++) begin
            s  = int'($urandom_range(255));
            go = ($urandom_range(3) == 0);
            game_over = go;
            strobe(8'(s));
            if ($urandom_range(1) == 1) begin
                d = int'($urandom_range(20, 1));
                repeat (d - 1) tick();
                s = int'($urandom_range(255));
                strobe(8'(s));
            end
            wait_idle($sformatf("rnd%0d", it), 60);
            check_digits($sformatf("rnd%0d s=%0d", it, s), model_disp(s, go));
        end
        game_over = 1'b0;

        // Reset in the middle of a conversion
        strobe(8'd255);
        repeat (7) tick();
        rst = 1'b1;
        #1;
        chk("mid rst anode", 32'(anode), 32'hF);
        chk("mid rst code", 32'(digit_code), 32'hFF);
        chk("mid rst busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        all_high = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (busy) all_high = 1'b1;
        end
        chk("mid rst no busy", 32'(all_high), 32'd0);
        check_digits("mid rst", 32'h0AFFFF00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
